// File: rtl/sub16_serial.sv
// Digit-serial subtractor: diff = a - b, DIGIT bits per clock, LSB digit first.
// Borrow, signed overflow and zero flags are registered with the final digit.
module sub16_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow,
    output logic             zero
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [DIGIT:0]   sum;
    logic [WIDTH-1:0] diff_next;
    logic             last;

    // Subtraction as a + ~b + 1: carry starts at 1, borrow is the inverted final carry.
    always_comb begin
        sum = {1'b0, a_r[cnt*DIGIT +: DIGIT]}
            + {1'b0, ~b_r[cnt*DIGIT +: DIGIT]}
            + {{DIGIT{1'b0}}, carry};
        diff_next = diff;
        diff_next[cnt*DIGIT +: DIGIT] = sum[DIGIT-1:0];
        last = (cnt == CW'(NDIG - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_r       <= '0;
            b_r       <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            diff      <= '0;
            borrow    <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r      <= a;
                        b_r      <= b;
                        carry    <= 1'b1;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    diff  <= diff_next;
                    carry <= sum[DIGIT];
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        borrow    <= ~sum[DIGIT];
                        overflow  <= (a_r[WIDTH-1] != b_r[WIDTH-1]) &&
                                     (diff_next[WIDTH-1] != a_r[WIDTH-1]);
                        zero      <= (diff_next == '0);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub16_serial.sv
// Scoreboard bench for sub16_serial: directed vectors, latency, backpressure
// and reset-abort checks; a negedge monitor pops expected results.
module tb_sub16_serial;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        borrow;
    logic        overflow;
    logic        zero;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] d;
        logic        br;
        logic        ov;
        logic        z;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    sub16_serial #(.WIDTH(16), .DIGIT(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .borrow(borrow), .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: compare whenever a result is handed over.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual=%h required=none", diff);
            end else begin
                mon_e = sb.pop_front();
                chk("diff",     {16'h0, diff},    {16'h0, mon_e.d});
                chk("borrow",   {31'h0, borrow},  {31'h0, mon_e.br});
                chk("overflow", {31'h0, overflow},{31'h0, mon_e.ov});
                chk("zero",     {31'h0, zero},    {31'h0, mon_e.z});
            end
        end
    end

    // Issue one operation and wait until out_valid, checking NDIG=4 latency.
    task automatic start_op(input logic [15:0] va, input logic [15:0] vb,
                            input logic [15:0] ed, input logic eb,
                            input logic eo, input logic ez);
        int lat;
        exp_t e;
        chk("in_ready_idle", {31'h0, in_ready}, 32'd1);
        e.d = ed; e.br = eb; e.ov = eo; e.z = ez;
        sb.push_back(e);
        a = va;
        b = vb;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'hDEAD;
        b = 16'hBEEF;
        chk("in_ready_run", {31'h0, in_ready}, 32'd0);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid && lat < 20);
        chk("latency", lat, 32'd4);
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("out_valid_after_hs", {31'h0, out_valid}, 32'd0);
        chk("in_ready_after_hs",  {31'h0, in_ready},  32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  {31'h0, in_ready},  32'd1);
        chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
        chk("rst_diff",      {16'h0, diff},      32'd0);
        chk("rst_flags",     {29'h0, borrow, overflow, zero}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        start_op(16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1); finish_op();
        start_op(16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0); finish_op();
        start_op(16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0); finish_op();
        start_op(16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1, 1'b0); finish_op();
        start_op(16'hFF2A, 16'hAAAA, 16'h5480, 1'b0, 1'b0, 1'b0); finish_op();
        start_op(16'hAAAA, 16'hFF2A, 16'hAB80, 1'b1, 1'b0, 1'b0); finish_op();
        start_op(16'h1234, 16'h0000, 16'h1234, 1'b0, 1'b0, 1'b0); finish_op();
        start_op(16'h8000, 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b1); finish_op();
        start_op(16'h0000, 16'h8000, 16'h8000, 1'b1, 1'b1, 1'b0); finish_op();

        // Backpressure: hold result for 5 cycles, pulse in_valid meanwhile.
        out_ready = 1'b0;
        start_op(16'h5555, 16'h1111, 16'h4444, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", {31'h0, out_valid}, 32'd1);
            chk("bp_diff",      {16'h0, diff},      32'h4444);
            chk("bp_in_ready",  {31'h0, in_ready},  32'd0);
            if (i == 2) begin
                a = 16'h0F0F;
                b = 16'h0101;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        finish_op();
        repeat (2) begin
            @(posedge clk); #1;
            chk("bp_no_accept", {31'h0, in_ready}, 32'd1);
        end

        // Reset two edges into RUN aborts the operation silently.
        a = 16'h9999;
        b = 16'h1111;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort_in_ready",  {31'h0, in_ready},  32'd1);
        chk("abort_out_valid", {31'h0, out_valid}, 32'd0);
        chk("abort_diff",      {16'h0, diff},      32'd0);
        chk("abort_flags",     {29'h0, borrow, overflow, zero}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("abort_no_output", {31'h0, out_valid}, 32'd0);
            @(posedge clk); #1;
        end
        start_op(16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0, 1'b0); finish_op();

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sub16_serial.md
Name: sub16_serial

Overview:
- Multi-cycle 16-bit unsigned/two's-complement subtractor: diff = a - b, computed DIGIT bits per clock, LSB digit first.
- Produces borrow, signed overflow and zero flags.
- Complements the single-cycle combinational adder in the arithmetic library. Used where area matters more than latency.
- valid/ready handshake on both input and output; one operation in flight at a time.

Parameters:
- WIDTH, 16, operand and result width in bits.
- DIGIT, 4, bits processed per cycle. Must divide WIDTH evenly. Latency NDIG = WIDTH/DIGIT.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands a, b valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- diff  output  WIDTH  (a - b) mod 2^WIDTH
- borrow  output  1  1 when a < b, unsigned
- overflow  output  1  signed two's-complement overflow
- zero  output  1  1 when diff == 0

Behaviour:
- Reset, asynchronous: state=IDLE, in_ready=1, out_valid=0, diff=0, borrow=0, overflow=0, zero=0. Internal registers are cleared. Any operation in progress is discarded without output.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - At an edge with in_valid=1, latch a and b into internal registers, set carry=1, digit counter=0, and go to RUN.
- RUN:
  - in_ready=0. in_valid is ignored.
  - Each edge computes {c_next, d} = a[k] + ~b[k] + carry over the DIGIT-bit slice k = counter.
  - The edge writes d into diff slice k, sets carry=c_next and increments the counter.
  - At the edge that processes slice NDIG-1, go to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - At an edge with out_ready=1, go to IDLE. out_valid is 0 after that edge.
  - diff and the flags stay stable for the whole time out_valid=1.
- Latency: with acceptance at edge E0, out_valid rises after edge E(NDIG), which is E4 by default. Throughput is one operation per NDIG+2 cycles minimum. There is no input/output overlap: in_ready stays 0 until the DONE handshake completes.
- Flags are registered together with the final slice, so they are valid when out_valid rises:
  - borrow = ~final carry.
  - overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).
  - zero = (full diff == 0).
- diff, borrow, overflow and zero keep their last values after the output handshake until the next operation overwrites them. In RUN, intermediate diff and flag values are don't-care for the consumer.
- Wrap-around: the result is always modulo 2^WIDTH. There is no saturation.
- Boundary cases:
  - a == b gives diff=0, zero=1, borrow=0, overflow=0.
  - b == 0 passes a through with borrow=0.
- Reset during RUN or DONE aborts to IDLE. in_ready=1 in the first cycle after reset release.
- in_valid held high across DONE is not accepted until IDLE. The operand sampled is the value present at the IDLE edge.

Test Plan:
- a=0x0000, b=0x0000 -> diff=0x0000, borrow=0, overflow=0, zero=1. out_valid rises exactly 4 cycles after acceptance.
- a=0x0000, b=0x0001 -> diff=0xFFFF, borrow=1, overflow=0, zero=0.
- a=0x8000, b=0x0001 -> diff=0x7FFF, borrow=0, overflow=1. Also a=0x7FFF, b=0xFFFF -> diff=0x8000, borrow=1, overflow=1.
- a=0xFF2A, b=0xAAAA -> diff=0x5480, borrow=0, overflow=0. Then a=0xAAAA, b=0xFF2A -> diff=0xAB80, borrow=1, overflow=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and diff stay stable and in_ready=0. A new in_valid pulse during DONE is not accepted. Raising out_ready returns the block to IDLE with in_ready=1 the next cycle.
- Assert rst for 1 cycle two edges into RUN -> all outputs are 0 immediately (asynchronous), out_valid never pulses for the aborted operation. The next operation a=0x1234, b=0x0234 gives diff=0x1000 with normal latency.
